// File: rtl/uart_rx_periph_pkg.sv
// Shared constants for the UART receive peripheral: bus addresses, CON bit
// layout, receive FSM encoding and the default oversample divider.
package uart_rx_periph_pkg;

  localparam int DIV_DEFAULT = 325;

  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_IRQ_EN   = 0;
  localparam int CON_NONEMPTY = 1;
  localparam int CON_OVR      = 2;
  localparam int CON_FERR     = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with pointers that wrap modulo DEPTH and an occupancy count.
// push/pop are single-cycle strobes: a pop is ignored while empty, and a push while
// full is ignored unless a pop is accepted in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observable after a push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped UART receiver: 16x oversampled 8N1 receive FSM feeding a byte
// FIFO, with RXD/CON registers and a level interrupt request.
module uart_rx_periph
  import uart_rx_periph_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic        C,
  input  logic        R,
  input  logic [31:0] Addr,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  input  logic        Rx,
  output logic        RxRdy,
  output rx_state_t   dbg_state
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  rx_state_t     state;
  logic          rx_meta, rxs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sub_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          irq_en, ovr, ferr;
  logic          push, pop, con_wr, nonempty, full;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic [31:0]   con_word;
  logic          unused_wdata;

  assign unused_wdata = &{1'b0, WData[31:4], WData[1]};

  assign dbg_state = state;
  assign tick      = (state != S_IDLE) && (tick_cnt == TICK_LAST);
  assign push      = (state == S_STOP) && tick && (sub_cnt == 4'd15) && rxs;
  assign nonempty  = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = MemRd && (Addr == ADDR_RXD) && nonempty;
  assign con_wr    = MemWr && (Addr == ADDR_CON);
  assign RxRdy     = irq_en & nonempty;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  // sub_cnt counts ticks within the current state; it wraps 15->0 on its own
  // so consecutive data bits are sampled every 16 ticks without reloading.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      sub_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr     <= 1'b0;
    end else begin
      if (con_wr && WData[CON_FERR]) ferr <= 1'b0;
      if (state == S_IDLE || tick) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + TW'(1);
      if (tick) sub_cnt <= sub_cnt + 4'd1;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            sub_cnt <= '0;
          end
        end
        S_START: begin
          if (tick && sub_cnt == 4'd7) begin
            sub_cnt <= '0;
            bit_cnt <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick && sub_cnt == 4'd15) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick && sub_cnt == 4'd15) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= S_WAITHI;
            end
          end
        end
        S_WAITHI: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new overrun wins over a same-cycle clear so the event is never lost.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      irq_en <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (con_wr) begin
        irq_en <= WData[CON_IRQ_EN];
        if (WData[CON_OVR]) ovr <= 1'b0;
      end
      if (push && full && !pop) ovr <= 1'b1;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (C),
    .rst_n (R),
    .push  (push),
    .pop   (pop),
    .din   (shreg),
    .dout  (dout),
    .count (count)
  );

  always_comb begin
    con_word               = '0;
    con_word[CON_IRQ_EN]   = irq_en;
    con_word[CON_NONEMPTY] = nonempty;
    con_word[CON_OVR]      = ovr;
    con_word[CON_FERR]     = ferr;
  end

  always_comb begin
    RData = '0;
    if (MemRd) begin
      if (Addr == ADDR_RXD && nonempty) RData = {24'b0, dout};
      else if (Addr == ADDR_CON)        RData = con_word;
    end
  end

endmodule
